// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared types for the writeback trace checker:
//   state_t  - checker state (IDLE, RUN, DONE, ERROR)
//   ERR_*    - error codes reported on err_code
//   entry_t  - one captured commit: {pc[31:0], wnum[4:0], wdata[31:0]}, 69 bits
// ---------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding captured commits until the golden trace catches up.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter. The head entry is visible combinationally.
// Ports:
//   clk, resetn      - clock, synchronous active-low reset
//   i_clear          - synchronous flush (used when the checker is re-armed)
//   i_push, i_data   - write one entry (caller guarantees not full, or a pop)
//   i_pop            - drop the head entry (caller guarantees not empty)
//   o_head           - current head entry, no read latency
//   o_full, o_empty  - occupancy flags
// ---------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   i_clear,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_data,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t         r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;

  // Pointer update; reset and flush both return to the empty condition
  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_trace_checker.sv
// ---------------------------------------------------------------------------
// wb_trace_checker
// Compares every committed register write from the CPU debug writeback port
// against a golden reference trace. Commits are buffered so the golden source
// may stall; the first mismatch, overflow (or timeout) and the end of trace
// are latched into sticky status outputs.
// Optional feature macro: TRACE_CHECK_TIMEOUT_EN adds a watchdog that raises
// err_code 3 after TIMEOUT_CYCLES cycles in RUN without a pop.
// Ports:
//   clk, resetn                      - clock, synchronous active-low reset
//   start                            - arms the checker (ignored in RUN)
//   wb_pc/wb_rf_wen/wb_rf_wnum/wb_rf_wdata - CPU writeback commit
//   ref_valid/ref_pc/ref_wnum/ref_wdata/ref_last - golden trace entry
//   ref_ready                        - golden entry consumed this cycle
//   busy                             - checker is in RUN
//   done/pass/error                  - sticky completion / result flags
//   err_code/err_pc/err_got/err_exp  - details of the first failure
//   commit_cnt                       - entries compared and matched
// ---------------------------------------------------------------------------
module wb_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] wb_pc,
  input  logic        wb_rf_wen,
  input  logic [4:0]  wb_rf_wnum,
  input  logic [31:0] wb_rf_wdata,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  input  logic        ref_last,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_got,
  output logic [31:0] err_exp,
  output logic [31:0] commit_cnt
);

  state_t      r_state;
  state_t      w_next;
  entry_t      w_head;
  entry_t      w_wb_entry;
  entry_t      w_ref_entry;
  logic        w_full;
  logic        w_empty;
  logic        w_run;
  logic        w_start_ok;
  logic        w_capture;
  logic        w_push;
  logic        w_pop;
  logic        w_mismatch;
  logic        w_overflow;
  logic        w_timeout;
  logic [31:0] w_tmo_pc;

  logic        r_done;
  logic        r_pass;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic [31:0] r_err_pc;
  logic [31:0] r_err_got;
  logic [31:0] r_err_exp;
  logic [31:0] r_commit_cnt;

  assign w_run       = (r_state == RUN);
  assign w_start_ok  = start && !w_run;
  assign w_wb_entry  = {wb_pc, wb_rf_wnum, wb_rf_wdata};
  assign w_ref_entry = {ref_pc, ref_wnum, ref_wdata};

  // Writes to r0 carry no architectural effect and are never traced
  assign w_capture  = w_run && wb_rf_wen && (wb_rf_wnum != 5'd0);
  assign w_pop      = w_run && !w_empty && ref_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then
  assign w_push     = w_capture && (!w_full || w_pop);
  assign w_overflow = w_capture && w_full && !w_pop;
  assign w_mismatch = w_pop && (w_head != w_ref_entry);

  assign ref_ready  = w_pop;
  assign busy       = w_run;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_start_ok),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wb_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef TRACE_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic [31:0]   r_last_pc;

  // Idle-cycle counter; restarts on every pop and whenever the checker is armed
  always_ff @(posedge clk) begin
    if (!resetn || w_start_ok || w_pop) begin
      r_tmo_cnt <= '0;
    end else if (w_run) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // PC of the most recently popped entry, reported on a timeout
  always_ff @(posedge clk) begin
    if (!resetn || w_start_ok) begin
      r_last_pc <= '0;
    end else if (w_pop) begin
      r_last_pc <= w_head.pc;
    end
  end

  // Fires on the edge at which the counter would reach TIMEOUT_CYCLES
  assign w_timeout = w_run && !w_pop && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_pc  = r_last_pc;
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
  assign w_tmo_pc     = 32'd0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; an error cycle never completes the trace
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (start) w_next = RUN;
      RUN: begin
        if (w_mismatch || w_overflow || w_timeout) w_next = ERROR;
        else if (w_pop && ref_last)                w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Sticky status; only the highest-priority event of the first error is kept
  always_ff @(posedge clk) begin
    if (!resetn || w_start_ok) begin
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_pc     <= '0;
      r_err_got    <= '0;
      r_err_exp    <= '0;
      r_commit_cnt <= '0;
    end else if (w_run) begin
      if (w_mismatch) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_MISMATCH;
        r_err_pc   <= w_head.pc;
        r_err_got  <= w_head.wdata;
        r_err_exp  <= ref_wdata;
      end else if (w_overflow) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_OVERFLOW;
        r_err_pc   <= wb_pc;
        r_err_got  <= wb_rf_wdata;
        r_err_exp  <= '0;
      end else if (w_timeout) begin
        r_error    <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
        r_err_pc   <= w_tmo_pc;
        r_err_got  <= '0;
        r_err_exp  <= '0;
      end else if (w_pop) begin
        r_commit_cnt <= r_commit_cnt + 32'd1;
        if (ref_last) begin
          r_done <= 1'b1;
          r_pass <= 1'b1;
        end
      end
    end
  end

  assign done       = r_done;
  assign pass       = r_pass;
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign err_pc     = r_err_pc;
  assign err_got    = r_err_got;
  assign err_exp    = r_err_exp;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Writeback trace checker that sits directly downstream of the CPU's debug writeback port and compares every committed register write against a golden reference trace. Commits are buffered in a small synchronous FIFO so the golden trace source may stall. The first mismatch, FIFO overflow or end of trace is latched into status outputs. It is a simulation and bring-up block and has no effect on CPU datapath behaviour.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; only used with `TRACE_CHECK_TIMEOUT_EN`.
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: pulse that arms the checker.
- `wb_pc` in 32: PC of the committing instruction.
- `wb_rf_wen` in 1: register write commit strobe.
- `wb_rf_wnum` in 5: destination register.
- `wb_rf_wdata` in 32: written value.
- `ref_valid` in 1: golden entry available.
- `ref_ready` out 1: golden entry consumed this cycle.
- `ref_pc` in 32: expected PC.
- `ref_wnum` in 5: expected destination register.
- `ref_wdata` in 32: expected written value.
- `ref_last` in 1: marks the final golden entry.
- `busy` out 1: state is RUN.
- `done` out 1: trace finished, sticky.
- `pass` out 1: done with no error, sticky.
- `error` out 1: sticky error flag.
- `err_code` out 2: 0 none, 1 mismatch, 2 overflow, 3 timeout.
- `err_pc` out 32: wb PC of the failing entry.
- `err_got` out 32: wdata of the failing entry.
- `err_exp` out 32: expected wdata of the failing entry.
- `commit_cnt` out 32: number of entries compared and matched.

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE when a matching entry is popped with `ref_last`=1.
  - RUN → ERROR on a mismatch, an overflow or a timeout.
  - DONE or ERROR → RUN on `start`. This clears the FIFO, `commit_cnt`, all flags and all err_* outputs.
  - `start` in RUN is ignored.
- Capture, RUN only: push {wb_pc, wb_rf_wnum, wb_rf_wdata} when `wb_rf_wen`=1 and `wb_rf_wnum`≠0. Commits to r0 and commits outside RUN are dropped.
- Compare:
  - `ref_ready` = RUN && FIFO not empty && `ref_valid`.
  - On `ref_ready`, pop the head and compare all three fields.
  - Any field differing → mismatch. Latch err_* from the head entry and the ref inputs.
  - Equal → `commit_cnt`+1.
- Overflow: push while full and no pop in the same cycle → ERROR, code 2. err_* take the dropped commit's pc and wdata; `err_exp`=0.
- Push and pop in the same cycle while full is legal; occupancy is unchanged.
- Priority when several events occur in one cycle: mismatch > overflow > timeout. Only the first error is latched. The error cycle's `ref_last` is ignored.
- In DONE and ERROR: no push, no pop, `ref_ready`=0. Outputs hold until `start` or reset.
- `commit_cnt` wraps modulo 2^32.

## Timing
- All state is updated on posedge `clk`.
- Reset (`resetn`=0 at an edge):
  - State becomes IDLE and the FIFO empties.
  - All outputs become 0, including `ref_ready` and `commit_cnt`.
  - Reset mid-RUN discards all buffered entries.
- A commit sampled at edge N is at the FIFO head after edge N. It can be compared in cycle N+1 at the earliest.
- `ref_ready` is combinational from state, FIFO empty and `ref_valid`. The golden source advances at the edge where `ref_ready`=1.
- Status outputs (`done`, `pass`, `error`, `err_*`, `commit_cnt`) are registered and update one edge after the deciding cycle.
- `busy` is combinational from state.

## Configuration
- `TRACE_CHECK_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN and resets on every pop and on entering RUN.
  - When it reaches `TIMEOUT_CYCLES` → ERROR, code 3, `err_pc`=last popped wb_pc (0 if none).
- Not defined: no counter is built and code 3 is never produced.

## Structure
- Package `trace_pkg` holds:
  - the state enum (IDLE, RUN, DONE, ERROR);
  - error-code constants;
  - the entry struct (69 bits: pc 32, wnum 5, wdata 32).
- Sub-module `trace_fifo`: synchronous FIFO of `DEPTH` entries with pointers that carry one extra wrap bit. Outputs are full, empty and head data, with no read latency.

## Test plan
- Matching trace: start, then commits (0xBFC00000, r3, 0x5), (0xBFC00004, r4, 0x9) with matching ref, last on the second → done=1, pass=1, commit_cnt=2, error=0.
- Data mismatch: commit r3=0x6, expected 0x5 → error=1, err_code=1, err_got=0x6, err_exp=0x5, `ref_ready`=0 afterwards.
- Filtering: commit with wnum=0, and a commit before `start` → no push, commit_cnt unchanged.
- Overflow: `ref_valid`=0 with DEPTH=16, then 17 consecutive commits → ERROR, err_code=2 after the 17th. Also, when full, a push with a simultaneous pop → no error.
- Reset mid-RUN: 3 entries buffered, `resetn`=0 for one edge → all outputs 0, state IDLE. After `start`, the first compare uses a fresh commit.
- With `TRACE_CHECK_TIMEOUT_EN`, TIMEOUT_CYCLES=8: start with no commits → err_code=3 eight cycles after entering RUN.
